// File: rtl/game_ctrl.sv
// Word-scramble game sequencer: mode select, round timer, round counter and request pulses.
// Optional GAMECTRL_MODE_TIME_EN: round length is ROUND_TICKS >> modeSel (minimum 1).
module game_ctrl #(
  parameter int TICK_DIV     = 50000000,
  parameter int ROUND_TICKS  = 30,
  parameter int RESULT_TICKS = 2,
  parameter int NUM_ROUNDS   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btnEnter,
  input  logic       btnUp,
  input  logic       guessValid,
  input  logic       guessCorrect,
  output logic [2:0] controlSig,
  output logic [7:0] modeDisp,
  output logic [1:0] modeSel,
  output logic       newWord,
  output logic       scoreInc,
  output logic       scoreClr,
  output logic [5:0] timeLeft,
  output logic [3:0] roundNum,
  output logic       gameOver
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW = (RESULT_TICKS > 1) ? $clog2(RESULT_TICKS + 1) : 1;

  // The state code is the display mux select, so controlSig comes straight off the state register.
  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    MODE   = 3'b001,
    PLAY   = 3'b010,
    RES_OK = 3'b011,
    FINAL  = 3'b100,
    RES_TO = 3'b101
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [1:0]      mode_sel_d;
  logic [5:0]      time_d, reload;
  logic [3:0]      round_d;
  logic [7:0]      mode_disp_d;
  logic            new_word_d, score_inc_d, score_clr_d, game_over_d;
  logic            tick, hold_end;

  assign controlSig = state_q;
  assign tick       = (presc_q == PW'(TICK_DIV - 1));

`ifdef GAMECTRL_MODE_TIME_EN
  logic [5:0] shifted;
  assign shifted = 6'(ROUND_TICKS) >> modeSel;
  assign reload  = (shifted == 6'd0) ? 6'd1 : shifted;
`else
  assign reload  = 6'(ROUND_TICKS);
`endif

  always_comb begin
    state_d     = state_q;
    presc_d     = '0;
    hold_d      = '0;
    mode_sel_d  = modeSel;
    time_d      = timeLeft;
    round_d     = roundNum;
    new_word_d  = 1'b0;
    score_inc_d = 1'b0;
    score_clr_d = 1'b0;
    hold_end    = 1'b0;
    case (state_q)
      IDLE: begin
        if (btnEnter) begin
          state_d     = MODE;
          score_clr_d = 1'b1;
          round_d     = 4'd0;
        end
      end
      MODE: begin
        if (btnEnter) begin
          state_d    = PLAY;
          new_word_d = 1'b1;
          round_d    = 4'd1;
          time_d     = reload;
        end else if (btnUp) begin
          mode_sel_d = modeSel + 2'd1;
        end
      end
      PLAY: begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        if (guessValid && guessCorrect) begin
          state_d     = RES_OK;
          score_inc_d = 1'b1;
          presc_d     = '0;
        end else if (tick) begin
          if (timeLeft <= 6'd1) begin
            time_d  = 6'd0;
            state_d = RES_TO;
            presc_d = '0;
          end else begin
            time_d = timeLeft - 6'd1;
          end
        end
      end
      RES_OK, RES_TO: begin
        presc_d  = tick ? '0 : presc_q + PW'(1);
        hold_d   = tick ? hold_q + HW'(1) : hold_q;
        hold_end = btnEnter || (tick && (hold_q == HW'(RESULT_TICKS - 1)));
        if (hold_end) begin
          presc_d = '0;
          hold_d  = '0;
          if (roundNum == 4'(NUM_ROUNDS)) begin
            state_d = FINAL;
          end else begin
            state_d    = PLAY;
            round_d    = roundNum + 4'd1;
            new_word_d = 1'b1;
            time_d     = reload;
          end
        end
      end
      FINAL: begin
        if (btnEnter) begin
          state_d = IDLE;
          round_d = 4'd0;
        end
      end
      default: begin
        state_d = IDLE;
        round_d = 4'd0;
      end
    endcase

    mode_disp_d = 8'hFF;
    if (state_d == MODE) begin
      case (mode_sel_d)
        2'd0:    mode_disp_d = 8'hF9;
        2'd1:    mode_disp_d = 8'hA4;
        2'd2:    mode_disp_d = 8'hB0;
        default: mode_disp_d = 8'h99;
      endcase
    end
    game_over_d = (state_d == FINAL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      presc_q  <= '0;
      hold_q   <= '0;
      modeSel  <= 2'd0;
      modeDisp <= 8'hFF;
      timeLeft <= 6'd0;
      roundNum <= 4'd0;
      newWord  <= 1'b0;
      scoreInc <= 1'b0;
      scoreClr <= 1'b0;
      gameOver <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      hold_q   <= hold_d;
      modeSel  <= mode_sel_d;
      modeDisp <= mode_disp_d;
      timeLeft <= time_d;
      roundNum <= round_d;
      newWord  <= new_word_d;
      scoreInc <= score_inc_d;
      scoreClr <= score_clr_d;
      gameOver <= game_over_d;
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl with TICK_DIV=4, ROUND_TICKS=3, RESULT_TICKS=1, NUM_ROUNDS=2.
module tb_game_ctrl;

  logic       clk = 1'b0;
  logic       rst, btnEnter, btnUp, guessValid, guessCorrect;
  logic [2:0] controlSig;
  logic [7:0] modeDisp;
  logic [1:0] modeSel;
  logic       newWord, scoreInc, scoreClr, gameOver;
  logic [5:0] timeLeft;
  logic [3:0] roundNum;

  int n_cmp = 0;
  int n_err = 0;

  game_ctrl #(.TICK_DIV(4), .ROUND_TICKS(3), .RESULT_TICKS(1), .NUM_ROUNDS(2)) dut (
    .clk(clk), .rst(rst), .btnEnter(btnEnter), .btnUp(btnUp),
    .guessValid(guessValid), .guessCorrect(guessCorrect),
    .controlSig(controlSig), .modeDisp(modeDisp), .modeSel(modeSel),
    .newWord(newWord), .scoreInc(scoreInc), .scoreClr(scoreClr),
    .timeLeft(timeLeft), .roundNum(roundNum), .gameOver(gameOver)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

`ifdef GAMECTRL_MODE_TIME_EN
  localparam int RELOAD_M1 = 1;
  localparam int WAIT_M1   = 2;
`else
  localparam int RELOAD_M1 = 3;
  localparam int WAIT_M1   = 4;
`endif

  logic [7:0] seg_seq [4];

  initial begin
    seg_seq[0] = 8'hA4; seg_seq[1] = 8'hB0; seg_seq[2] = 8'h99; seg_seq[3] = 8'hF9;
    rst = 1'b1; btnEnter = 1'b0; btnUp = 1'b0; guessValid = 1'b0; guessCorrect = 1'b0;
    step(2);
    chk("rst_ctrl", controlSig, 3'b000);
    chk("rst_disp", modeDisp, 8'hFF);
    chk("rst_round", roundNum, 0);
    chk("rst_time", timeLeft, 0);
    chk("rst_pulses", {newWord, scoreInc, scoreClr, gameOver}, 4'b0000);
    chk("rst_mode", modeSel, 0);
    rst = 1'b0;

    btnEnter = 1'b1; step(1); btnEnter = 1'b0;
    chk("idle_clr", scoreClr, 1);
    chk("mode_ctrl", controlSig, 3'b001);
    chk("mode_disp0", modeDisp, 8'hF9);
    step(1);
    chk("clr_once", scoreClr, 0);
    for (int i = 0; i < 4; i++) begin
      btnUp = 1'b1; step(1); btnUp = 1'b0;
      chk($sformatf("up_disp%0d", i), modeDisp, seg_seq[i]);
    end
    chk("mode_wrap", modeSel, 0);

    btnEnter = 1'b1; btnUp = 1'b1; step(1); btnEnter = 1'b0; btnUp = 1'b0;
    chk("play_ctrl", controlSig, 3'b010);
    chk("play_newword", newWord, 1);
    chk("play_round", roundNum, 1);
    chk("play_time", timeLeft, 3);
    chk("enter_wins", modeSel, 0);
    chk("play_disp", modeDisp, 8'hFF);

    for (int i = 1; i <= 12; i++) begin
      step(1);
      chk($sformatf("to_time%0d", i), timeLeft, 3 - i / 4);
      chk($sformatf("to_ctrl%0d", i), controlSig, (i == 12) ? 3'b101 : 3'b010);
      chk($sformatf("to_inc%0d", i), scoreInc, 0);
      if (i == 1) chk("newword_once", newWord, 0);
    end

    for (int i = 1; i <= 4; i++) begin
      step(1);
      chk($sformatf("hold_to%0d", i), controlSig, (i == 4) ? 3'b010 : 3'b101);
    end
    chk("r2_round", roundNum, 2);
    chk("r2_newword", newWord, 1);
    chk("r2_time", timeLeft, 3);

    for (int i = 1; i <= 11; i++) begin
      if (i == 5) guessValid = 1'b1;
      step(1);
      guessValid = 1'b0;
      chk($sformatf("r2_ctrl%0d", i), controlSig, 3'b010);
    end
    chk("r2_time_pre", timeLeft, 1);
    guessValid = 1'b1; guessCorrect = 1'b1; step(1); guessValid = 1'b0; guessCorrect = 1'b0;
    chk("ok_ctrl", controlSig, 3'b011);
    chk("ok_inc", scoreInc, 1);
    chk("ok_time", timeLeft, 1);
    step(1);
    chk("inc_once", scoreInc, 0);
    guessValid = 1'b1; guessCorrect = 1'b1; step(1); guessValid = 1'b0; guessCorrect = 1'b0;
    chk("res_guess_ign", scoreInc, 0);
    step(1);
    chk("ok_hold", controlSig, 3'b011);
    step(1);
    chk("final_ctrl", controlSig, 3'b100);
    chk("final_over", gameOver, 1);
    chk("final_nonew", newWord, 0);

    btnEnter = 1'b1; step(1); btnEnter = 1'b0;
    chk("back_idle", controlSig, 3'b000);
    chk("idle_round", roundNum, 0);
    chk("idle_over", gameOver, 0);

    btnEnter = 1'b1; step(1); btnEnter = 1'b0;
    btnUp = 1'b1; step(1); btnUp = 1'b0;
    chk("m1_disp", modeDisp, 8'hA4);
    btnEnter = 1'b1; step(1); btnEnter = 1'b0;
    chk("m1_reload", timeLeft, RELOAD_M1);
    chk("m1_mode", modeSel, 1);
    step(WAIT_M1);
    chk("m1_mid", timeLeft, RELOAD_M1 - 1 + (WAIT_M1 == 2 ? 1 : 0));
    rst = 1'b1; btnEnter = 1'b1; guessValid = 1'b1; guessCorrect = 1'b1;
    step(1);
    rst = 1'b0; btnEnter = 1'b0; guessValid = 1'b0; guessCorrect = 1'b0;
    chk("mid_rst_ctrl", controlSig, 3'b000);
    chk("mid_rst_time", timeLeft, 0);
    chk("mid_rst_round", roundNum, 0);
    chk("mid_rst_mode", modeSel, 0);
    chk("mid_rst_inc", scoreInc, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
